// File: rtl/lc3_dbg_pkg.sv
// Shared constants and state encoding for the register-file debug dump scanner.
package lc3_dbg_pkg;

  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned SR_W        = 3;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  // Header + two bytes per register + checksum.
  localparam int unsigned FRAME_BYTES = 2 * NUM_REGS + 2;

  // Cycles spent per register with an always-ready transmitter: SEL, STROBE, CAP, SEND_HI, SEND_LO.
  localparam int unsigned REG_CYCLES  = 5;

  // Start edge to the edge that raises done, with an always-ready transmitter.
  localparam int unsigned DONE_LATENCY = 1 + REG_CYCLES * NUM_REGS + 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEL,
    ST_STROBE,
    ST_CAP,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_SUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug scanner: walks registers 0..NUM_REGS-1 through the debug read port and
// streams header, register bytes (high first) and an XOR checksum to the UART.
module regfile_dump
  import lc3_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              clk_r,
  output logic [SR_W-1:0]   SR_r,
  input  logic [DATA_W-1:0] Out_r,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   capture, capture_nx;
  logic [BYTE_W-1:0]   checksum, checksum_nx;
  logic [SR_W-1:0]     index, index_nx;

  logic                busy_nx;
  logic                done_nx;
  logic                clk_r_nx;
  logic [SR_W-1:0]     sr_nx;
  logic [BYTE_W-1:0]   tx_data_nx;
  logic                tx_valid_nx;
  logic                accept_c;
  logic                last_reg_c;

  assign accept_c   = tx_valid & tx_ready;
  assign last_reg_c = (index == SR_W'(NUM_REGS - 1));

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      capture  <= '0;
      checksum <= '0;
      index    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clk_r    <= 1'b0;
      SR_r     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      capture  <= capture_nx;
      checksum <= checksum_nx;
      index    <= index_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      clk_r    <= clk_r_nx;
      SR_r     <= sr_nx;
      tx_data  <= tx_data_nx;
      tx_valid <= tx_valid_nx;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_nx    = state;
    capture_nx  = capture;
    checksum_nx = checksum;
    index_nx    = index;
    busy_nx     = busy;
    done_nx     = 1'b0;
    clk_r_nx    = 1'b0;
    sr_nx       = SR_r;
    tx_data_nx  = tx_data;
    tx_valid_nx = tx_valid;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx    = ST_HDR;
          busy_nx     = 1'b1;
          checksum_nx = '0;
          index_nx    = '0;
          tx_valid_nx = 1'b1;
          tx_data_nx  = HDR_BYTE;
        end
      end

      ST_HDR: begin
        if (accept_c) begin
          state_nx    = ST_SEL;
          tx_valid_nx = 1'b0;
          sr_nx       = index;
        end
      end

      ST_SEL: begin
        state_nx = ST_STROBE;
        clk_r_nx = 1'b1;
      end

      ST_STROBE: begin
        state_nx = ST_CAP;
      end

      // Out_r is only read on this edge, so the high byte is forwarded straight into tx_data.
      ST_CAP: begin
        state_nx    = ST_SEND_HI;
        capture_nx  = Out_r;
        tx_valid_nx = 1'b1;
        tx_data_nx  = Out_r[DATA_W-1:BYTE_W];
      end

      ST_SEND_HI: begin
        if (accept_c) begin
          state_nx    = ST_SEND_LO;
          checksum_nx = checksum ^ capture[DATA_W-1:BYTE_W];
          tx_data_nx  = capture[BYTE_W-1:0];
        end
      end

      ST_SEND_LO: begin
        if (accept_c) begin
          checksum_nx = checksum ^ capture[BYTE_W-1:0];
          if (last_reg_c) begin
            state_nx   = ST_SUM;
            tx_data_nx = checksum_nx;
          end else begin
            state_nx    = ST_SEL;
            tx_valid_nx = 1'b0;
            index_nx    = index + SR_W'(1);
            sr_nx       = index + SR_W'(1);
          end
        end
      end

      ST_SUM: begin
        if (accept_c) begin
          state_nx    = ST_DONE;
          tx_valid_nx = 1'b0;
          busy_nx     = 1'b0;
          done_nx     = 1'b1;
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx    = ST_IDLE;
        busy_nx     = 1'b0;
        tx_valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump with a behavioural register file and frame model.
module tb_regfile_dump;
  import lc3_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic        busy, done, clk_r, tx_valid;
  logic [2:0]  SR_r;
  logic [15:0] Out_r;
  logic [7:0]  tx_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [NUM_REGS];
  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  logic [2:0]  sr_seq[$];
  logic        busy_tr[$];
  logic [15:0] new_r1, new_r5;

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_clk_r = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [2:0]  prev_sr = '0;

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .clk_r(clk_r), .SR_r(SR_r), .Out_r(Out_r), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Register file debug port: registered read on the strobe.
  always @(posedge clk_r or negedge reset) begin
    if (!reset) Out_r <= '0;
    else        Out_r <= mem[SR_r];
  end

  // Stream monitor: collects accepted bytes, checks stall hold and strobe shape.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      prev_clk_r = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
        end
      end
      if (clk_r === 1'b1 && !prev_clk_r) begin
        sr_seq.push_back(SR_r);
        checks++;
        if (SR_r !== prev_sr) begin
          errors++;
          $display("FAIL sr_setup: SR_r=%0d at strobe, required %0d from SEL", SR_r, prev_sr);
        end
      end
      if (prev_clk_r) begin
        checks++;
        if (clk_r !== 1'b0 || SR_r !== prev_sr) begin
          errors++;
          $display("FAIL strobe_cap: clk_r=%b SR_r=%0d, required clk_r=0 SR_r=%0d", clk_r, SR_r, prev_sr);
        end
      end
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_clk_r = clk_r;
      prev_sr    = SR_r;
    end
  end

  // Frame a perfect dumper would send for the given register contents.
  function automatic void build_exp(input logic [15:0] regs [NUM_REGS]);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(regs[i][15:8]);
      exp_q.push_back(regs[i][7:0]);
      x = x ^ regs[i][15:8] ^ regs[i][7:0];
    end
    exp_q.push_back(x);
  endfunction

  task automatic compare_frame(input string tag);
    checks++;
    if (rx.size() != FRAME_BYTES) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, required %0d", tag, rx.size(), FRAME_BYTES);
    end
    for (int i = 0; i < FRAME_BYTES && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, required %h", tag, i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  // mode 0: ready high; 1: random ready with 20-cycle header/checksum stalls;
  // 2: start re-raised from edge 10 and held; 3: registers rewritten at edge 10.
  task automatic run_frame(input int mode, output int done_k);
    int hs, cs;
    hs = 0; cs = 0; done_k = -1;
    rx.delete(); sr_seq.delete(); busy_tr.delete();
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      start = (mode == 2) ? (k >= 9) : 1'b0;
      if (mode == 3 && k == 10) begin
        mem[1] = new_r1;
        mem[5] = new_r5;
      end
      if (mode == 1) begin
        if (tx_valid && rx.size() == 0 && hs < 20) begin
          tx_ready = 1'b0; hs++;
        end else if (tx_valid && rx.size() == FRAME_BYTES - 1 && cs < 20) begin
          tx_ready = 1'b0; cs++;
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        tx_ready = 1'b1;
      end
      @(negedge clk);
      busy_tr.push_back(busy);
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL frame_timeout: done not seen within 400 cycles (mode %0d)", mode);
    end
    if (mode == 1) begin
      checks++;
      if (hs != 20 || cs != 20) begin
        errors++;
        $display("FAIL stall_len: header stall %0d checksum stall %0d, required 20 and 20", hs, cs);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, clk_r, tx_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/clk_r/valid=%b, required 0000", {busy, done, clk_r, tx_valid});
    end
    checks++;
    if (SR_r !== 3'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: SR_r=%0d tx_data=%h, required 0 and 00", SR_r, tx_data);
    end
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: busy=%b valid=%b, required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_basic();
    int dk;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    build_exp(mem);
    run_frame(0, dk);
    compare_frame("basic");
    checks++;
    if (rx.size() == FRAME_BYTES && rx[FRAME_BYTES-1] !== 8'h26) begin
      errors++;
      $display("FAIL basic_chk: got %h, required 26", rx[FRAME_BYTES-1]);
    end
    checks++;
    if (dk != 42) begin
      errors++;
      $display("FAIL basic_latency: done after %0d cycles, required 42", dk);
    end
    for (int k = 0; k < busy_tr.size(); k++) begin
      checks++;
      if (busy_tr[k] !== (k < 42)) begin
        errors++;
        $display("FAIL basic_busy%0d: got %b, required %b", k, busy_tr[k], (k < 42));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_strobe();
    int dk;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem[i] = 16'(16'h1100 * (i + 1) + i);
      x = x ^ mem[i][15:8] ^ mem[i][7:0];
    end
    build_exp(mem);
    run_frame(0, dk);
    compare_frame("strobe");
    checks++;
    if (sr_seq.size() != NUM_REGS) begin
      errors++;
      $display("FAIL sr_count: %0d strobes, required %0d", sr_seq.size(), NUM_REGS);
    end
    for (int i = 0; i < NUM_REGS && i < sr_seq.size(); i++) begin
      checks++;
      if (sr_seq[i] !== 3'(i)) begin
        errors++;
        $display("FAIL sr_seq%0d: got %0d, required %0d", i, sr_seq[i], i);
      end
    end
    checks++;
    if (rx.size() == FRAME_BYTES && rx[FRAME_BYTES-1] !== x) begin
      errors++;
      $display("FAIL strobe_chk: got %h, required %h", rx[FRAME_BYTES-1], x);
    end
  endtask

  task automatic test_backpressure();
    int dk;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'($urandom);
    build_exp(mem);
    run_frame(1, dk);
    compare_frame("bp");
    tx_ready = 1'b1;
  endtask

  task automatic test_start_hold();
    int dk;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'($urandom);
    build_exp(mem);
    run_frame(2, dk);
    compare_frame("hold");
    checks++;
    if (dk != 42) begin
      errors++;
      $display("FAIL hold_latency: done after %0d cycles, required 42", dk);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: busy=%b valid=%b after DONE, required 0 0", busy, tx_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL hold_restart: busy=%b valid=%b data=%h, required 1 1 a5", busy, tx_valid, tx_data);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int dk;
    bit found;
    found = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'($urandom);
    rx.delete();
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tx_valid && rx.size() == 7) begin
        found = 1'b1;
        tx_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || tx_data !== mem[3][15:8]) begin
      errors++;
      $display("FAIL r3_hi: found=%0d data=%h, required 1 and %h", found, tx_data, mem[3][15:8]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, clk_r, tx_valid} !== 4'b0000 || SR_r !== 3'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy/done/clk_r/valid=%b SR_r=%0d data=%h, required 0000 0 00",
               {busy, done, clk_r, tx_valid}, SR_r, tx_data);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    build_exp(mem);
    run_frame(0, dk);
    compare_frame("after_reset");
  endtask

  task automatic test_write_mid();
    int dk;
    logic [15:0] snap [NUM_REGS];
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'($urandom);
    new_r1 = ~mem[1];
    new_r5 = ~mem[5];
    snap = mem;
    snap[5] = new_r5;
    build_exp(snap);
    run_frame(3, dk);
    compare_frame("midwrite");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_backpressure();
    test_start_hold();
    test_reset_mid();
    test_write_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
